alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (16-bit in1/in2, 3-bit alu_op, alu_out, zero flag z) between NUM_REQ core-side requesters.
- Round-robin arbitration, per-requester valid/ready request and response handshakes.
- Operands and results are registered, so the ALU sits between two register stages.
- Placed in the cluster datapath between the core execute stages and the shared ALU instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, operand/result width
OP_W, 3, ALU opcode width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted, one-hot or zero
req_in1  in  NUM_REQ*DATA_W  operand 1; requester i at bits [i*DATA_W +: DATA_W]
req_in2  in  NUM_REQ*DATA_W  operand 2, same packing
req_op  in  NUM_REQ*OP_W  opcode, same packing
rsp_valid  out  NUM_REQ  response valid, one-hot or zero
rsp_ready  in  NUM_REQ  response accepted per requester
rsp_data  out  DATA_W  result, shared bus, meaningful only with rsp_valid
rsp_z  out  1  captured ALU zero flag
alu_in1  out  DATA_W  to ALU in1
alu_in2  out  DATA_W  to ALU in2
alu_op  out  OP_W  to ALU alu_op
alu_out  in  DATA_W  from ALU
alu_z  in  1  from ALU z

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_z=0, alu_in1=0, alu_in2=0, alu_op=0, grant=0, rr_ptr=0.
- Reset is honoured mid-operation. The FSM returns to IDLE and any in-flight operation and response are discarded.

IDLE state:
- Winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- req_ready[winner]=1 is asserted combinationally in the same cycle; this is the only state in which req_ready can be nonzero.
- On accept: register that requester's in1, in2 and op into the operand registers, record grant=winner, go to EXEC.
- No req_valid: stay in IDLE. Operand registers hold 0, so the ALU sees op 0 (NOP).

EXEC state:
- alu_in1/alu_in2/alu_op are driven from the operand registers for this one cycle.
- At the end of the cycle, alu_out and alu_z are captured into rsp_data and rsp_z; go to RESP.

RESP state:
- rsp_valid[grant]=1, all other bits 0. rsp_data/rsp_z stay stable while waiting.
- If rsp_ready[grant]=1: go to IDLE, set rr_ptr=(grant+1) mod NUM_REQ, clear the operand registers to 0.
- rsp_ready bits of non-granted requesters are ignored.

Timing and rules:
- Latency: accept in cycle T → rsp_valid high from T+2. Minimum issue interval is 3 cycles when rsp_ready is already high.
- A requester must hold req_valid and its operands until req_ready.
- Deasserting req_valid before accept is legal; that request is simply not considered.
- A requester being granted while also holding its own pending response cannot occur: there is one outstanding operation at a time.
- rr_ptr wraps from NUM_REQ-1 to 0.
- All arithmetic is inside the ALU; this block does no width conversion.

Optional Feature:
- Macro: ALU_ARB_PERF_EN
- Enabled:
  - Adds output perf_wait_cnt (16 bits): counts clk cycles in which some req_valid bit is 1 but no req_ready bit is 1.
  - Saturates at 16'hFFFF; reset to 0 by rst_n.
  - Adds output perf_ops (16 bits): increments on each completed response handshake, wraps at 16'hFFFF→0.
- Disabled: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-EXEC → all outputs 0 immediately (asynchronous); after release, first request is granted from requester 0 position.
- Single request: req0 op=3'd1 (add), in1=5, in2=20, rsp_ready0 held 1 → req_ready0 at T, alu_op=1 at T+1, rsp_valid0=1 with rsp_data=25, rsp_z=0 at T+2, back to IDLE at T+3.
- Zero flag: req2 op=3'd2 (sub), in1=20, in2=20 → rsp_data=0, rsp_z=1 on rsp_valid[2].
- Round robin: all four req_valid held high continuously → grant order 0,1,2,3,0; each rsp_valid one-hot in the matching bit.
- Backpressure: rsp_ready1=0 for 5 cycles with a req0 pending → rsp_valid1 and rsp_data held stable, req_ready stays 0; on rsp_ready1=1, req0 is granted next (rr_ptr=2 wraps to 0).
- ALU_ARB_PERF_EN: during the backpressure scenario, perf_wait_cnt increments by at least 5 and perf_ops increments by 1 per completed response.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU; optional perf counters under ALU_ARB_PERF_EN
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_z,
  output logic [DATA_W-1:0]         alu_in1,
  output logic [DATA_W-1:0]         alu_in2,
  output logic [OP_W-1:0]           alu_op,
`ifdef ALU_ARB_PERF_EN
  output logic [15:0]               perf_wait_cnt,
  output logic [15:0]               perf_ops,
`endif
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_z
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant;
  logic [DATA_W-1:0]  opr_in1;
  logic [DATA_W-1:0]  opr_in2;
  logic [OP_W-1:0]    opr_op;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic               accept;
  logic               complete;
  logic [PTR_W-1:0]   grant_inc;

  // Round-robin scan starting at rr_ptr; first valid requester wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign grant_inc = (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + PTR_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs; rst_n gates the combinational ready
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && win_found) begin
          req_ready  = NUM_REQ'(1) << win_idx;
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = NUM_REQ'(1) << grant;
        if (rsp_ready[grant]) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on accept, result capture after EXEC, pointer advance on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr_in1  <= '0;
      opr_in2  <= '0;
      opr_op   <= '0;
      grant    <= '0;
      rr_ptr   <= '0;
      rsp_data <= '0;
      rsp_z    <= 1'b0;
    end else begin
      if (accept) begin
        opr_in1 <= req_in1[int'(win_idx)*DATA_W +: DATA_W];
        opr_in2 <= req_in2[int'(win_idx)*DATA_W +: DATA_W];
        opr_op  <= req_op[int'(win_idx)*OP_W +: OP_W];
        grant   <= win_idx;
      end
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_z    <= alu_z;
      end
      if (complete) begin
        rr_ptr  <= grant_inc;
        opr_in1 <= '0;
        opr_in2 <= '0;
        opr_op  <= '0;
      end
    end
  end

  // ALU sees operands only during EXEC, otherwise a zero NOP
  assign alu_in1 = (state == EXEC) ? opr_in1 : '0;
  assign alu_in2 = (state == EXEC) ? opr_in2 : '0;
  assign alu_op  = (state == EXEC) ? opr_op  : '0;

`ifdef ALU_ARB_PERF_EN
  // Saturating count of stalled-request cycles and wrapping count of completed responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_wait_cnt <= '0;
      perf_ops      <= '0;
    end else begin
      if ((|req_valid) && !(|req_ready) && (perf_wait_cnt != 16'hFFFF))
        perf_wait_cnt <= perf_wait_cnt + 16'd1;
      if (complete)
        perf_ops <= perf_ops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_in1;
  logic [N*DW-1:0] req_in2;
  logic [N*OW-1:0] req_op;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_z;
  logic [DW-1:0]   alu_in1;
  logic [DW-1:0]   alu_in2;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_out;
  logic            alu_z;
`ifdef ALU_ARB_PERF_EN
  logic [15:0]     perf_wait_cnt;
  logic [15:0]     perf_ops;
`endif

  int compared   = 0;
  int mismatched = 0;

  alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_z(rsp_z),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
`ifdef ALU_ARB_PERF_EN
    .perf_wait_cnt(perf_wait_cnt), .perf_ops(perf_ops),
`endif
    .alu_out(alu_out), .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  // Reference ALU: 1 = add, 2 = sub, anything else yields 0
  always_comb begin
    case (alu_op)
      3'd1:    alu_out = alu_in1 + alu_in2;
      3'd2:    alu_out = alu_in1 - alu_in2;
      default: alu_out = '0;
    endcase
    alu_z = (alu_out == '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    req_in1[i*DW +: DW] = a;
    req_in2[i*DW +: DW] = b;
    req_op[i*OW +: OW]  = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_in1 = '0; req_in2 = '0; req_op = '0;
    step(); step();
    compared++; if (rsp_valid !== 4'b0000) begin mismatched++; $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); end
    compared++; if (rsp_data !== 16'h0000) begin mismatched++; $display("FAIL reset_rsp_data: got %h exp 0000", rsp_data); end
    rst_n = 1'b1;
    set_req(3, 16'd9, 16'd1, 3'd2);
    req_valid = 4'b1000;
    #1;
    compared++; if (req_ready !== 4'b1000) begin mismatched++; $display("FAIL reset_pre_grant3: got %b exp 1000", req_ready); end
    step();
    req_valid = 4'b0000;
    compared++; if (alu_op !== 3'd2) begin mismatched++; $display("FAIL reset_exec_op: got %0d exp 2", alu_op); end
    #2 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    compared++; if (alu_op !== 3'd0 || alu_in1 !== 16'd0 || alu_in2 !== 16'd0) begin mismatched++; $display("FAIL reset_async_alu: got op=%0d in1=%h in2=%h exp 0/0/0", alu_op, alu_in1, alu_in2); end
    compared++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_z !== 1'b0) begin mismatched++; $display("FAIL reset_async_hs: got rr=%b rv=%b z=%b exp 0", req_ready, rsp_valid, rsp_z); end
    #1 rst_n = 1'b1;
    #1;
    compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL reset_first_grant: got %b exp 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    set_req(0, 16'd5, 16'd20, 3'd1);
    req_valid = 4'b0001; rsp_ready = 4'b0001;
    #1;
    compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    compared++; if (alu_op !== 3'd1 || alu_in1 !== 16'd5 || alu_in2 !== 16'd20) begin mismatched++; $display("FAIL single_exec: got op=%0d in1=%0d in2=%0d exp 1/5/20", alu_op, alu_in1, alu_in2); end
    compared++; if (rsp_valid !== 4'b0000) begin mismatched++; $display("FAIL single_exec_rv: got %b exp 0000", rsp_valid); end
    step();
    compared++; if (rsp_valid !== 4'b0001 || rsp_data !== 16'd25 || rsp_z !== 1'b0) begin mismatched++; $display("FAIL single_rsp: got rv=%b d=%0d z=%b exp 0001/25/0", rsp_valid, rsp_data, rsp_z); end
    step();
    compared++; if (rsp_valid !== 4'b0000 || alu_op !== 3'd0) begin mismatched++; $display("FAIL single_idle: got rv=%b op=%0d exp 0000/0", rsp_valid, alu_op); end
  endtask

  task automatic test_zero_flag();
    set_req(2, 16'd20, 16'd20, 3'd2);
    req_valid = 4'b0100; rsp_ready = 4'b0100;
    #1;
    compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("FAIL zero_ready: got %b exp 0100", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    compared++; if (rsp_valid !== 4'b0100 || rsp_data !== 16'd0 || rsp_z !== 1'b1) begin mismatched++; $display("FAIL zero_rsp: got rv=%b d=%0d z=%b exp 0100/0/1", rsp_valid, rsp_data, rsp_z); end
    step();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] sums [5] = '{16'd107, 16'd208, 16'd309, 16'd410, 16'd107};
    logic [N-1:0] onehot;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) set_req(i, DW'(100 * (i + 1)), DW'(i + 7), 3'd1);
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      onehot = 4'b0001 << order[g];
      #1;
      compared++; if (req_ready !== onehot) begin mismatched++; $display("FAIL rr_grant%0d: got %b exp %b", g, req_ready, onehot); end
      step();
      step();
      compared++; if (rsp_valid !== onehot || rsp_data !== sums[g]) begin mismatched++; $display("FAIL rr_rsp%0d: got rv=%b d=%0d exp %b/%0d", g, rsp_valid, rsp_data, onehot, sums[g]); end
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
`ifdef ALU_ARB_PERF_EN
    logic [15:0] wait0, ops0;
`endif
    set_req(1, 16'd50, 16'd8, 3'd2);
    set_req(0, 16'd3, 16'd4, 3'd1);
    req_valid = 4'b0010; rsp_ready = 4'b0000;
    #1;
    compared++; if (req_ready !== 4'b0010) begin mismatched++; $display("FAIL bp_grant1: got %b exp 0010", req_ready); end
    step();
    req_valid = 4'b0001;
    #1;
    compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL bp_exec_ready: got %b exp 0000", req_ready); end
    step();
`ifdef ALU_ARB_PERF_EN
    wait0 = perf_wait_cnt;
`endif
    rsp_ready = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      compared++; if (rsp_valid !== 4'b0010 || rsp_data !== 16'd42 || rsp_z !== 1'b0) begin mismatched++; $display("FAIL bp_hold%0d: got rv=%b d=%0d z=%b exp 0010/42/0", c, rsp_valid, rsp_data, rsp_z); end
      compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL bp_ready%0d: got %b exp 0000", c, req_ready); end
      step();
    end
`ifdef ALU_ARB_PERF_EN
    compared++; if (perf_wait_cnt - wait0 < 16'd5) begin mismatched++; $display("FAIL perf_wait: got delta %0d exp >=5", perf_wait_cnt - wait0); end
    ops0 = perf_ops;
`endif
    rsp_ready = 4'b0010;
    step();
`ifdef ALU_ARB_PERF_EN
    compared++; if (perf_ops !== ops0 + 16'd1) begin mismatched++; $display("FAIL perf_ops: got %0d exp %0d", perf_ops, ops0 + 16'd1); end
`endif
    compared++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0001) begin mismatched++; $display("FAIL bp_wrap_grant0: got rv=%b rr=%b exp 0000/0001", rsp_valid, req_ready); end
    rsp_ready = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    compared++; if (rsp_valid !== 4'b0001 || rsp_data !== 16'd7) begin mismatched++; $display("FAIL bp_req0_rsp: got rv=%b d=%0d exp 0001/7", rsp_valid, rsp_data); end
    step();
    compared++; if (rsp_valid !== 4'b0000) begin mismatched++; $display("FAIL bp_final_idle: got %b exp 0000", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_flag();
    test_round_robin();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
